// File: rtl/idli_fetch_m_if.sv
// rtl/idli_fetch_m_if.sv - SQI pad bundle between the fetch sequencer and serial memory
interface idli_fetch_m_if;
   logic       o_fch_sqi_cs_n;
   logic [3:0] o_fch_sqi_sio;
   logic       o_fch_sqi_oe;
   logic [3:0] i_fch_sqi_sio;

   modport master (
      output o_fch_sqi_cs_n,
      output o_fch_sqi_sio,
      output o_fch_sqi_oe,
      input  i_fch_sqi_sio
   );

   modport slave (
      input  o_fch_sqi_cs_n,
      input  o_fch_sqi_sio,
      input  o_fch_sqi_oe,
      output i_fch_sqi_sio
   );
endinterface

// File: rtl/idli_fetch_m.sv
// rtl/idli_fetch_m.sv - instruction fetch sequencer streaming nibbles from SQI memory to the decoder
// Owns the fetch PC; stalls and redirects end the SQI read and reissue it at the new PC.
module idli_fetch_m #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          DUMMY_NIB = 2
) (
   input  logic           i_fch_gck,
   input  logic           i_fch_rst_n,
   input  logic           i_fch_stall,
   input  logic           i_fch_redir,
   input  logic [15:0]    i_fch_redir_pc,
   idli_fetch_m_if.master io_fch_sqi,
   output logic [3:0]     o_fch_enc,
   output logic           o_fch_enc_vld,
   output logic           o_fch_flush,
   output logic [15:0]    o_fch_pc
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_DUMMY  = 3'd3;
   localparam logic [2:0] S_STREAM = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

   localparam logic [2:0] CMD_LAST   = 3'd1;
   localparam logic [2:0] ADDR_LAST  = 3'd5;
   localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIB - 1);

   logic [2:0]  r_state, w_state_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic [1:0]  r_nib, w_nib_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic        r_boot, w_boot_nxt;
   logic        r_cs_n, w_cs_n_nxt;
   logic        r_oe, w_oe_nxt;
   logic [3:0]  r_sio, w_sio_nxt;
   logic        w_bnd_stall;
   logic [23:0] w_addr;
   logic [23:0] w_addr_sh;

   assign w_bnd_stall = (r_nib == 2'd0) && i_fch_stall;
   assign w_addr      = {7'b0, r_pc, 1'b0};
   assign w_addr_sh   = w_addr >> {(ADDR_LAST - w_cnt_nxt), 2'b00};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_nib_nxt   = r_nib;
      w_pc_nxt    = r_pc;
      w_boot_nxt  = r_boot;
      if (i_fch_redir) begin
         w_pc_nxt    = i_fch_redir_pc;
         w_nib_nxt   = 2'd0;
         w_cnt_nxt   = 3'd0;
         w_state_nxt = S_GAP;
      end else begin
         case (r_state)
            S_IDLE: begin
               // The boot flag forces the very first fetch even if stall is already high.
               if (r_boot || !i_fch_stall) begin
                  w_state_nxt = S_CMD;
                  w_cnt_nxt   = 3'd0;
                  w_boot_nxt  = 1'b0;
               end
            end
            S_CMD: begin
               w_cnt_nxt = r_cnt + 3'd1;
               if (r_cnt == CMD_LAST) begin
                  w_state_nxt = S_ADDR;
                  w_cnt_nxt   = 3'd0;
               end
            end
            S_ADDR: begin
               w_cnt_nxt = r_cnt + 3'd1;
               if (r_cnt == ADDR_LAST) begin
                  w_state_nxt = S_DUMMY;
                  w_cnt_nxt   = 3'd0;
               end
            end
            S_DUMMY: begin
               w_cnt_nxt = r_cnt + 3'd1;
               if (r_cnt == DUMMY_LAST) begin
                  w_state_nxt = S_STREAM;
                  w_cnt_nxt   = 3'd0;
               end
            end
            S_STREAM: begin
               if (w_bnd_stall) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_nib_nxt = r_nib + 2'd1;
                  if (r_nib == 2'd3) begin
                     w_pc_nxt = r_pc + 16'd1;
                  end
               end
            end
            S_GAP: begin
               w_state_nxt = S_CMD;
               w_cnt_nxt   = 3'd0;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 3'd0;
            end
         endcase
      end
   end

   // Pad outputs are decoded from the next state so the flops line up with the state they describe.
   always_comb begin
      w_cs_n_nxt = 1'b1;
      w_oe_nxt   = 1'b0;
      w_sio_nxt  = 4'h0;
      case (w_state_nxt)
         S_CMD: begin
            w_cs_n_nxt = 1'b0;
            w_oe_nxt   = 1'b1;
            w_sio_nxt  = (w_cnt_nxt == 3'd0) ? 4'h0 : 4'h3;
         end
         S_ADDR: begin
            w_cs_n_nxt = 1'b0;
            w_oe_nxt   = 1'b1;
            w_sio_nxt  = w_addr_sh[3:0];
         end
         S_DUMMY, S_STREAM: begin
            w_cs_n_nxt = 1'b0;
         end
         default: begin
            w_cs_n_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
      if (!i_fch_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_nib   <= 2'd0;
         r_pc    <= RESET_PC;
         r_boot  <= 1'b1;
         r_cs_n  <= 1'b1;
         r_oe    <= 1'b0;
         r_sio   <= 4'h0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_nib   <= w_nib_nxt;
         r_pc    <= w_pc_nxt;
         r_boot  <= w_boot_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_oe    <= w_oe_nxt;
         r_sio   <= w_sio_nxt;
      end
   end

   assign io_fch_sqi.o_fch_sqi_cs_n = r_cs_n;
   assign io_fch_sqi.o_fch_sqi_oe   = r_oe;
   assign io_fch_sqi.o_fch_sqi_sio  = r_sio;

   assign o_fch_enc     = io_fch_sqi.i_fch_sqi_sio;
   assign o_fch_enc_vld = (r_state == S_STREAM) && !i_fch_redir && !w_bnd_stall;
   assign o_fch_flush   = i_fch_redir && i_fch_rst_n;
   assign o_fch_pc      = r_pc;
endmodule

// File: tb/tb_idli_fetch_m.sv
// tb/tb_idli_fetch_m.sv - SQI memory model and instruction-stream reference for idli_fetch_m
module tb_idli_fetch_m;
   localparam int DN    = 2;
   localparam int DATA0 = 8 + DN;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [15:0] redir_pc = 16'h0;
   logic [3:0]  enc;
   logic        enc_vld;
   logic        flush;
   logic [15:0] pc;
   logic [3:0]  sio_in = 4'h0;

   int n_chk = 0;
   int n_err = 0;

   idli_fetch_m_if sqi ();
   assign sqi.i_fch_sqi_sio = sio_in;

   idli_fetch_m #(.RESET_PC(16'h0000), .DUMMY_NIB(DN)) dut (
      .i_fch_gck      (clk),
      .i_fch_rst_n    (rst_n),
      .i_fch_stall    (stall),
      .i_fch_redir    (redir),
      .i_fch_redir_pc (redir_pc),
      .io_fch_sqi     (sqi),
      .o_fch_enc      (enc),
      .o_fch_enc_vld  (enc_vld),
      .o_fch_flush    (flush),
      .o_fch_pc       (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] nib_of(input logic [15:0] w, input int i);
      return 4'((w >> (4 * (3 - i))) & 16'hF);
   endfunction

   // Serial memory: counts cycles since chip select fell, latches the address, streams words.
   logic [15:0] mem [65536];
   int          mcnt = 0;
   logic [23:0] maddr = 24'h0;

   always @(posedge clk) begin : mem_model
      int nc;
      int n;
      logic [23:0] na;
      na = maddr;
      if (sqi.o_fch_sqi_cs_n) begin
         nc = 0;
      end else begin
         nc = mcnt + 1;
         if (mcnt >= 2 && mcnt < 8) na = {maddr[19:0], sqi.o_fch_sqi_sio};
      end
      mcnt  <= nc;
      maddr <= na;
      if (nc >= DATA0) begin
         n = nc - DATA0;
         sio_in <= nib_of(mem[16'(na[16:1] + 16'(n / 4))], n % 4);
      end else begin
         sio_in <= 4'h0;
      end
   end

   // Reference: the decoder must see mem[pc] nibbles in order; pc advances per word, jumps on redirect.
   bit          mon_en = 1'b0;
   logic [15:0] mpc = 16'h0;
   int          mnib = 0;

   always @(negedge clk) begin : monitor
      logic exp_vld;
      if (mon_en && rst_n) begin
         if (!sqi.o_fch_sqi_cs_n) begin
            if (mcnt < 2) chk("m_cmd", 32'(sqi.o_fch_sqi_sio), (mcnt == 0) ? 32'h0 : 32'h3);
            chk("m_oe", 32'(sqi.o_fch_sqi_oe), 32'(mcnt < 8));
            if (mcnt == 8) chk("m_addr", 32'(maddr), 32'({7'b0, mpc, 1'b0}));
         end
         exp_vld = !sqi.o_fch_sqi_cs_n && (mcnt >= DATA0) && !redir && !(mnib == 0 && stall);
         chk("m_vld", 32'(enc_vld), 32'(exp_vld));
         chk("m_flush", 32'(flush), 32'(redir));
         chk("m_pc", 32'(pc), 32'(mpc));
         if (exp_vld) begin
            chk("m_enc", 32'(enc), 32'(nib_of(mem[mpc], mnib)));
            mnib = (mnib + 1) % 4;
            if (mnib == 0) mpc = mpc + 16'd1;
         end
         if (redir) begin
            mpc  = redir_pc;
            mnib = 0;
         end
      end
   end

   task automatic wait_cs_low(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = !sqi.o_fch_sqi_cs_n;
      end
      chk(tag, 32'(found), 32'h1);
   endtask

   task automatic lat_to_vld(input string tag);
      int n = 0;
      while (!enc_vld && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n), 32'(DATA0));
   endtask

   task automatic wait_vld(input int want, input string tag);
      int got = 0;
      for (int i = 0; i < 100 && got < want; i++) begin
         @(negedge clk);
         if (enc_vld) got++;
      end
      chk(tag, 32'(got), 32'(want));
   endtask

   task automatic pulse_redir(input logic [15:0] target);
      @(posedge clk); #1;
      redir    = 1'b1;
      redir_pc = target;
      @(negedge clk);
      chk("redir_flush", 32'(flush), 32'h1);
      chk("redir_vld", 32'(enc_vld), 32'h0);
      @(posedge clk); #1;
      redir = 1'b0;
   endtask

   initial begin
      logic [3:0] exp4 [8];
      int         nv;
      bit         rose;
      exp4 = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};

      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'hC123;
      mem[1] = 16'h0000;

      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(sqi.o_fch_sqi_cs_n), 32'h1);
      chk("rst_oe", 32'(sqi.o_fch_sqi_oe), 32'h0);
      chk("rst_sio", 32'(sqi.o_fch_sqi_sio), 32'h0);
      chk("rst_vld", 32'(enc_vld), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_pc", 32'(pc), 32'h0);

      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      wait_cs_low("t1_cs");
      lat_to_vld("t1_lat");
      repeat (4) @(negedge clk);
      chk("t1_pc", 32'(pc), 32'h1);

      nv   = 0;
      rose = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (enc_vld) nv++;
         if (sqi.o_fch_sqi_cs_n) rose = 1'b1;
      end
      chk("t2_run", 32'(nv), 32'd8);
      chk("t2_cs", 32'(rose), 32'h0);
      @(negedge clk);
      chk("t2_pc", 32'(pc), 32'h3);

      pulse_redir(16'h0000);
      wait_vld(6, "t3_w");
      @(posedge clk); #1;
      stall = 1'b1;
      @(negedge clk);
      chk("t3_n2", 32'(enc_vld), 32'h1);
      @(negedge clk);
      chk("t3_n3", 32'(enc_vld), 32'h1);
      @(negedge clk);
      chk("t3_bnd", 32'(enc_vld), 32'h0);
      chk("t3_pc", 32'(pc), 32'h2);
      @(negedge clk);
      chk("t3_cs", 32'(sqi.o_fch_sqi_cs_n), 32'h1);
      repeat (5) @(posedge clk);
      #1 stall = 1'b0;
      wait_cs_low("t3_re");
      lat_to_vld("t3_lat");
      chk("t3_pc2", 32'(pc), 32'h2);

      pulse_redir(16'h1234);
      @(negedge clk);
      chk("t4_gap", 32'(sqi.o_fch_sqi_cs_n), 32'h1);
      wait_cs_low("t4_cs");
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         chk("t4_sio", 32'(sqi.o_fch_sqi_sio), 32'(exp4[i]));
      end
      chk("t4_pc", 32'(pc), 32'h1234);

      wait_vld(3, "t5_w");
      pulse_redir(16'hABCD);
      @(negedge clk);
      chk("t5_pc", 32'(pc), 32'hABCD);

      pulse_redir(16'hFFFF);
      wait_vld(1, "t6_w");
      nv   = 0;
      rose = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (enc_vld) nv++;
         if (sqi.o_fch_sqi_cs_n) rose = 1'b1;
         if (i == 4) chk("wrap_pc", 32'(pc), 32'h0);
      end
      chk("wrap_run", 32'(nv), 32'd7);
      chk("wrap_cs", 32'(rose), 32'h0);

      pulse_redir(16'h0100);
      wait_cs_low("ar_cs");
      repeat (3) @(negedge clk);
      #2;
      mon_en = 1'b0;
      stall  = 1'b1;
      rst_n  = 1'b0;
      #1;
      chk("ar_cs_n", 32'(sqi.o_fch_sqi_cs_n), 32'h1);
      chk("ar_oe", 32'(sqi.o_fch_sqi_oe), 32'h0);
      chk("ar_sio", 32'(sqi.o_fch_sqi_sio), 32'h0);
      chk("ar_vld", 32'(enc_vld), 32'h0);
      chk("ar_pc", 32'(pc), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      mpc    = 16'h0;
      mnib   = 0;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      wait_cs_low("boot_go");
      repeat (20) @(posedge clk);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (redir) begin
            redir = 1'b0;
         end else if ($urandom_range(0, 49) == 0) begin
            redir    = 1'b1;
            redir_pc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1))
                                                   : 16'($urandom);
         end
         if ($urandom_range(0, 15) == 0) stall = !stall;
      end
      @(posedge clk); #1;
      redir = 1'b0;
      stall = 1'b0;
      repeat (30) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
